// File: rtl/swin_win3x3_sum.sv
// 3x3 box-sum stage behind swin_wrap: turns three aligned 16-pixel line words into
// 16 parallel 3x3 sums per word, with horizontal neighbours carried across words.
module swin_win3x3_sum #(
  parameter int WORDS_PER_ROW = 32,
  parameter int PIX_W         = 8,
  parameter int SUM_W         = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [16*PIX_W-1:0] data_in_line_0,
  input  logic [16*PIX_W-1:0] data_in_line_1,
  input  logic [16*PIX_W-1:0] data_in_line_2,
  input  logic                data_in_vld,
  output logic [16*SUM_W-1:0] data_out_sum,
  output logic                data_out_vld,
  output logic                data_out_sol,
  output logic                data_out_eol
);

  localparam int CW    = PIX_W + 2;
  localparam int CNT_W = (WORDS_PER_ROW > 2) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WORDS_PER_ROW - 1);

  logic [16*PIX_W-1:0] cur0_q, cur1_q, cur2_q, cur0_d, cur1_d, cur2_d;
  logic [CW-1:0]       lft_q, lft_d;
  logic [CNT_W-1:0]    colCnt_q, colCnt_d;
  logic                flush_q, flush_d;
  logic [16*SUM_W-1:0] sum_q, sum_d;
  logic                vld_q, vld_d, sol_q, sol_d, eol_q, eol_d;

  logic [15:0][CW-1:0] cIn, cCur;
  logic [17:0][CW-1:0] ext;
  logic [CW-1:0]       rightNbr;
  logic                emit;

  function automatic logic [15:0][CW-1:0] colSums(input logic [16*PIX_W-1:0] a,
                                                  input logic [16*PIX_W-1:0] b,
                                                  input logic [16*PIX_W-1:0] c);
    logic [15:0][CW-1:0] r;
    for (int k = 0; k < 16; k++) begin
      r[k] = CW'(a[PIX_W*k +: PIX_W]) + CW'(b[PIX_W*k +: PIX_W]) + CW'(c[PIX_W*k +: PIX_W]);
    end
    return r;
  endfunction

  // A flush and a col-0 word can coincide; the col-0 path never emits, so the
  // single output register is never contended.
  always_comb begin
    cIn      = colSums(data_in_line_0, data_in_line_1, data_in_line_2);
    cCur     = colSums(cur0_q, cur1_q, cur2_q);
    cur0_d   = cur0_q;
    cur1_d   = cur1_q;
    cur2_d   = cur2_q;
    lft_d    = lft_q;
    colCnt_d = colCnt_q;
    flush_d  = 1'b0;
    emit     = 1'b0;
    rightNbr = cIn[0];
    vld_d    = 1'b0;
    sol_d    = 1'b0;
    eol_d    = 1'b0;

    if (flush_q) begin
      emit     = 1'b1;
      rightNbr = cCur[15];
      eol_d    = 1'b1;
    end

    if (data_in_vld) begin
      if (colCnt_q == '0) begin
        lft_d = cIn[0];
      end else begin
        emit     = 1'b1;
        rightNbr = cIn[0];
        sol_d    = (colCnt_q == CNT_W'(1));
        lft_d    = cCur[15];
      end
      cur0_d   = data_in_line_0;
      cur1_d   = data_in_line_1;
      cur2_d   = data_in_line_2;
      colCnt_d = (colCnt_q == LAST_COL) ? '0 : colCnt_q + CNT_W'(1);
      flush_d  = (colCnt_q == LAST_COL);
    end

    vld_d = emit;
  end

  // ext[0] is the left neighbour of lane 0, ext[17] the right neighbour of lane 15.
  always_comb begin
    ext[0]     = lft_q;
    ext[16:1]  = cCur;
    ext[17]    = rightNbr;
    sum_d      = sum_q;
    if (emit) begin
      for (int k = 0; k < 16; k++) begin
        sum_d[SUM_W*k +: SUM_W] = SUM_W'(ext[k]) + SUM_W'(ext[k+1]) + SUM_W'(ext[k+2]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur0_q   <= '0;
      cur1_q   <= '0;
      cur2_q   <= '0;
      lft_q    <= '0;
      colCnt_q <= '0;
      flush_q  <= 1'b0;
      sum_q    <= '0;
      vld_q    <= 1'b0;
      sol_q    <= 1'b0;
      eol_q    <= 1'b0;
    end else begin
      cur0_q   <= cur0_d;
      cur1_q   <= cur1_d;
      cur2_q   <= cur2_d;
      lft_q    <= lft_d;
      colCnt_q <= colCnt_d;
      flush_q  <= flush_d;
      sum_q    <= sum_d;
      vld_q    <= vld_d;
      sol_q    <= sol_d;
      eol_q    <= eol_d;
    end
  end

  assign data_out_sum = sum_q;
  assign data_out_vld = vld_q;
  assign data_out_sol = sol_q;
  assign data_out_eol = eol_q;

endmodule
